// File: rtl/arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//
// Contents:
//   arb_state_t        - arbiter FSM state encoding (IDLE, BUSY_I, BUSY_D)
//   STARVE_MAX_DEFAULT - consecutive data wins before a waiting fetch is forced
//   TIMEOUT_DEFAULT    - cycles allowed in a busy state before giving up on m_ready
//   cnt_width()        - width of a counter that must hold the values 0..max_val
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int STARVE_MAX_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT    = 16;

    // Never returns less than one bit, so a zero-valued parameter still
    // yields a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Wait/timeout counter for the memory port arbiter.
//
// Counts the cycles the arbiter spends waiting on the shared memory. The
// count restarts from zero whenever clear is high, advances on every cycle
// with en high, and expired flags the enabled cycle that is the TIMEOUT-th
// one of the current wait.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset (count to 0)
//   clear   in   restart the count (held high while the arbiter is idle)
//   en      in   count this cycle (arbiter is waiting on memory)
//   expired out  this enabled cycle completes TIMEOUT cycles of waiting
module mem_arb_timer
    import arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int            CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // The count saturates at LAST so an enabled-but-unanswered wait never
    // wraps back to a small value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt holds the number of waiting cycles already completed, so the
    // cycle that sees LAST is the TIMEOUT-th one.
    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port
// and a data (load/store) port.
//
// Arbitration happens only in IDLE. Data wins by default, but after
// STARVE_MAX consecutive data grants made while a fetch was waiting, the
// fetch is forced through. The granted command is latched and held on the
// memory bus until m_ready, or until TIMEOUT cycles pass, in which case the
// port gets valid together with err and keeps its previous read data.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   if_req, if_addr               fetch request and byte address
//   if_rdata, if_valid, if_err    fetch read data, completion pulse, timeout flag
//   d_req, d_we, d_addr,
//   d_wdata, d_be                 data request, write enable, address, data, byte enables
//   d_rdata, d_valid, d_err       data read data, completion pulse, timeout flag
//   m_req, m_we, m_addr,
//   m_wdata, m_be                 shared memory command
//   m_rdata, m_ready              memory read data and completion strobe
//   stall_if, stall_mem           pipeline stalls for the IF and MEM stages
//
// State  | meaning
// IDLE   | no transaction; arbitration and the bubble between transactions
// BUSY_I | fetch command on the memory bus, waiting for m_ready or timeout
// BUSY_D | data command on the memory bus, waiting for m_ready or timeout
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_err,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_be,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,

    output logic              stall_if,
    output logic              stall_mem
);

    localparam int            SW         = cnt_width(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              grant_i;
    logic              grant_d;
    logic              busy;
    logic              expired;

    logic [SW-1:0]     starve_cnt;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        lat_be;

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                // Once the starvation limit is reached the data port only
                // yields to a fetch that is actually waiting; with no fetch
                // pending, data keeps being served.
                if (d_req && ((starve_cnt < STARVE_TOP) || !if_req)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (if_req) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready || expired) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counts data wins taken over a waiting fetch.
    always_ff @(posedge clk) begin
        if (reset || grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req && (starve_cnt < STARVE_TOP)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Command latches: loaded only on the grant edge, so requester inputs
    // may change freely while the transaction is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_be    <= 4'b0000;
        end else if (grant_d) begin
            lat_addr  <= d_addr;
            lat_we    <= d_we;
            lat_wdata <= d_wdata;
            lat_be    <= d_be;
        end else if (grant_i) begin
            lat_addr  <= if_addr;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_be    <= 4'b1111;
        end
    end

    // Completion. m_ready takes priority over a timeout in the same cycle,
    // and only a real m_ready updates the port's read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= '0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            if_valid <= (state == BUSY_I) && (m_ready || expired);
            if_err   <= (state == BUSY_I) && expired && !m_ready;
            d_valid  <= (state == BUSY_D) && (m_ready || expired);
            d_err    <= (state == BUSY_D) && expired && !m_ready;
            if ((state == BUSY_I) && m_ready) begin
                if_rdata <= m_rdata;
            end
            if ((state == BUSY_D) && m_ready) begin
                d_rdata <= m_rdata;
            end
        end
    end

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!busy),
        .en      (busy),
        .expired (expired)
    );

    assign m_req   = busy;
    assign m_we    = lat_we;
    assign m_addr  = lat_addr;
    assign m_wdata = lat_wdata;
    assign m_be    = lat_be;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
//
// The stimulus pushes each command it expects to see on the memory bus, in
// grant order, onto exp_cmd_q. A memory model pops it when a new m_req
// appears, checks the command and its stability, answers after the
// command's delay (0 = never answer) and pushes the expected completion
// (port, read data, err, cycle) onto exp_cpl_q. A monitor pops that queue on
// every valid pulse.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;

    typedef struct {
        bit          is_d;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        int          delay;
    } cmd_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        int          vcyc;
    } cpl_t;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_be;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_err;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [3:0]        m_be;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;
    logic              stall_if;
    logic              stall_mem;

    cmd_t        exp_cmd_q[$];
    cpl_t        exp_cpl_q[$];
    logic [31:0] last_rd[2];
    logic [31:0] mon_if_rd;
    logic [31:0] mon_d_rd;
    bit          idle_noise;
    int          cyc;
    int          n_cmp;
    int          n_mis;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_err     (d_err),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_be      (m_be),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_cmd(input bit is_d, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] addr, input int delay);
        cmd_t c;
        c.is_d  = is_d;
        c.we    = we;
        c.be    = be;
        c.wdata = wdata;
        c.addr  = addr;
        c.delay = delay;
        exp_cmd_q.push_back(c);
    endtask

    task automatic wait_valid(input string tag, input bit is_d, input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(is_d ? d_valid : if_valid) && (n < budget));
        check_val(tag, is_d ? d_valid : if_valid, 1'b1);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory model.
    initial begin
        bit          in_txn;
        int          ready_cyc;
        int          seq;
        logic [31:0] rd_val;
        logic [31:0] seq_v;
        cmd_t        cur;
        cpl_t        cpl;
        in_txn    = 1'b0;
        ready_cyc = -1;
        seq       = 0;
        rd_val    = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        cur = '{is_d: 1'b0, we: 1'b0, be: 4'h0, wdata: 32'h0, addr: 32'h0, delay: 0};
        m_ready = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_cpl_q.delete();
                last_rd[0] = '0;
                last_rd[1] = '0;
                in_txn     = 1'b0;
                ready_cyc  = -1;
            end
            #1;
            if (m_req) begin
                if (!in_txn) begin
                    in_txn    = 1'b1;
                    ready_cyc = -1;
                    check_val("cmd_avail", exp_cmd_q.size() != 0, 1'b1);
                    if (exp_cmd_q.size() != 0) begin
                        cur = exp_cmd_q.pop_front();
                        check_val("cmd_addr", m_addr, cur.addr);
                        check_val("cmd_we", m_we, cur.we);
                        check_val("cmd_be", m_be, cur.be);
                        if (cur.is_d) check_val("cmd_wdata", m_wdata, cur.wdata);
                        cpl.is_d = cur.is_d;
                        if (cur.delay == 0) begin
                            cpl.rdata = last_rd[cur.is_d];
                            cpl.err   = 1'b1;
                            cpl.vcyc  = cyc + TIMEOUT;
                        end else begin
                            seq++;
                            seq_v     = seq;
                            rd_val    = 32'hC3A5_0000 ^ {cur.addr[15:0], seq_v[15:0]};
                            cpl.rdata = rd_val;
                            cpl.err   = 1'b0;
                            cpl.vcyc  = cyc + cur.delay;
                            ready_cyc = cyc + cur.delay - 1;
                            last_rd[cur.is_d] = rd_val;
                        end
                        exp_cpl_q.push_back(cpl);
                    end
                end else begin
                    check_val("hold_cmd",
                              {m_we, m_be, m_addr, cur.is_d ? m_wdata : 32'h0},
                              {cur.we, cur.be, cur.addr, cur.is_d ? cur.wdata : 32'h0});
                end
                if (cyc == ready_cyc) begin
                    m_ready = 1'b1;
                    m_rdata = rd_val;
                end else begin
                    m_ready = 1'b0;
                    m_rdata = $urandom;
                end
            end else begin
                in_txn  = 1'b0;
                m_ready = idle_noise;
                m_rdata = $urandom;
            end
        end
    end

    // Completion monitor.
    initial begin
        cpl_t c;
        mon_if_rd = '0;
        mon_d_rd  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_if_rd = '0;
                mon_d_rd  = '0;
                continue;
            end
            if (if_valid || d_valid) begin
                check_val("one_valid", if_valid && d_valid, 1'b0);
                check_val("cpl_avail", exp_cpl_q.size() != 0, 1'b1);
                if (exp_cpl_q.size() != 0) begin
                    c = exp_cpl_q.pop_front();
                    check_val("cpl_port", d_valid, c.is_d);
                    check_val("cpl_cycle", cyc, c.vcyc);
                    if (c.is_d) begin
                        mon_d_rd = c.rdata;
                        check_val("cpl_err", {if_err, d_err}, {1'b0, c.err});
                    end else begin
                        mon_if_rd = c.rdata;
                        check_val("cpl_err", {if_err, d_err}, {c.err, 1'b0});
                    end
                end
            end else begin
                check_val("err_quiet", {if_err, d_err}, 2'b00);
            end
            check_val("if_rdata", if_rdata, mon_if_rd);
            check_val("d_rdata", d_rdata, mon_d_rd);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int n;
        n_cmp      = 0;
        n_mis      = 0;
        idle_noise = 1'b0;
        reset      = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_addr     = '0;
        d_wdata    = '0;
        d_be       = 4'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_mreq", m_req, 1'b0);
        check_val("rst_flags", {if_valid, d_valid, if_err, d_err}, 4'h0);
        check_val("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        check_val("rst_latch", {m_we, m_be, m_addr, m_wdata}, 69'h0);
        reset = 1'b0;

        // Lone fetch, answered on the first m_req cycle.
        @(posedge clk); #1;
        push_cmd(1'b0, 1'b0, 4'hF, 32'h0, 32'h40, 1);
        if_req  = 1'b1;
        if_addr = 32'h40;
        #1;
        check_val("lone_stall_c0", stall_if, 1'b1);
        check_val("lone_mreq_c0", m_req, 1'b0);
        @(posedge clk); #1;
        check_val("lone_stall_c1", stall_if, 1'b1);
        check_val("lone_mreq_c1", m_req, 1'b1);
        check_val("lone_maddr", m_addr, 32'h40);
        @(posedge clk); #1;
        check_val("lone_valid_c2", if_valid, 1'b1);
        check_val("lone_stall_c2", stall_if, 1'b0);
        if_req = 1'b0;

        // Simultaneous requests: data write first, fetch after one bubble.
        // m_ready is also pulsed in idle cycles and must be ignored.
        @(posedge clk); #1;
        idle_noise = 1'b1;
        push_cmd(1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 32'h100, 1);
        push_cmd(1'b0, 1'b0, 4'hF, 32'h0, 32'h44, 3);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_wdata = 32'hDEADBEEF;
        d_be    = 4'hF;
        if_req  = 1'b1;
        if_addr = 32'h44;
        wait_valid("sim_d_valid", 1'b1, 20);
        d_req = 1'b0;
        d_we  = 1'b0;
        check_val("sim_bubble_mreq", m_req, 1'b0);
        @(posedge clk); #1;
        check_val("sim_if_mreq", m_req, 1'b1);
        check_val("sim_if_mwe", m_we, 1'b0);
        wait_valid("sim_if_valid", 1'b0, 20);
        if_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle_noise = 1'b0;

        // Requester inputs change and the request drops while waiting.
        push_cmd(1'b1, 1'b1, 4'b0011, 32'h12345678, 32'h10, 4);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h10;
        d_wdata = 32'h12345678;
        d_be    = 4'b0011;
        @(posedge clk); #1;
        check_val("chg_stall_mem", stall_mem, 1'b1);
        @(posedge clk); #1;
        d_addr  = 32'h20;
        d_wdata = 32'hFFFF0000;
        d_be    = 4'hC;
        d_we    = 1'b0;
        d_req   = 1'b0;
        check_val("chg_maddr", m_addr, 32'h10);
        wait_valid("chg_valid", 1'b1, 20);

        // Starvation: both held, expected grant order D,D,D,D,I,D.
        @(posedge clk); #1;
        push_cmd(1'b1, 1'b0, 4'hF, 32'hAAAA5555, 32'h200, 2);
        push_cmd(1'b1, 1'b0, 4'hF, 32'hAAAA5555, 32'h200, 2);
        push_cmd(1'b1, 1'b0, 4'hF, 32'hAAAA5555, 32'h200, 2);
        push_cmd(1'b1, 1'b0, 4'hF, 32'hAAAA5555, 32'h200, 2);
        push_cmd(1'b0, 1'b0, 4'hF, 32'h0, 32'h80, 1);
        push_cmd(1'b1, 1'b0, 4'hF, 32'hAAAA5555, 32'h200, 2);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h200;
        d_wdata = 32'hAAAA5555;
        d_be    = 4'hF;
        if_req  = 1'b1;
        if_addr = 32'h80;
        got = 0;
        n   = 0;
        while ((got < 6) && (n < 200)) begin
            @(posedge clk); #1;
            n++;
            if (if_valid || d_valid) got++;
        end
        check_val("starve_six", got, 6);
        d_req  = 1'b0;
        if_req = 1'b0;

        // Timeout: memory never answers.
        @(posedge clk); #1;
        push_cmd(1'b1, 1'b0, 4'hF, 32'h0, 32'h300, 0);
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h300;
        d_wdata = 32'h0;
        d_be    = 4'hF;
        wait_valid("to_valid", 1'b1, 40);
        check_val("to_err", d_err, 1'b1);
        check_val("to_idle_mreq", m_req, 1'b0);
        check_val("to_stall_mem", stall_mem, 1'b0);
        d_req = 1'b0;

        // Reset while in BUSY_D abandons the transaction.
        @(posedge clk); #1;
        push_cmd(1'b1, 1'b0, 4'hF, 32'h0, 32'h500, 0);
        d_req  = 1'b1;
        d_addr = 32'h500;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check_val("pre_rst_mreq", m_req, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("mid_rst_mreq", m_req, 1'b0);
        check_val("mid_rst_dvalid", d_valid, 1'b0);
        check_val("mid_rst_starve", dut.starve_cnt, 0);
        reset = 1'b0;
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("post_rst_dvalid", d_valid, 1'b0);

        // New fetch after reset completes normally.
        push_cmd(1'b0, 1'b0, 4'hF, 32'h0, 32'h600, 3);
        if_req  = 1'b1;
        if_addr = 32'h600;
        wait_valid("post_rst_if", 1'b0, 20);
        if_req = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check_val("cmd_q_empty", exp_cmd_q.size(), 0);
        check_val("cpl_q_empty", exp_cpl_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL be the byte-address width on all ports.
REQ-002 Parameter DATA_W, default 32, SHALL be the data width on all ports.
REQ-003 Parameter STARVE_MAX, default 4, SHALL be the number of consecutive data wins after which fetch is forced.
REQ-004 Parameter TIMEOUT, default 16, SHALL be the maximum number of cycles spent waiting for m_ready.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port if_req / if_addr, input, 1 / ADDR_W: instruction-fetch request and its address.
REQ-008 Port if_rdata / if_valid / if_err, output, DATA_W / 1 / 1: fetch read data, completion pulse, and timeout flag.
REQ-009 Port d_req / d_we / d_addr / d_wdata / d_be, input, 1 / 1 / ADDR_W / DATA_W / 4: data request (MemRead or MemWrite), write enable, address, write data, byte enables.
REQ-010 Port d_rdata / d_valid / d_err, output, DATA_W / 1 / 1: data read data, completion pulse, and timeout flag.
REQ-011 Port m_req / m_we / m_addr / m_wdata / m_be, output, 1 / 1 / ADDR_W / DATA_W / 4: the shared single-port memory command.
REQ-012 Port m_rdata / m_ready, input, DATA_W / 1: memory read data and completion strobe.
REQ-013 Port stall_if / stall_mem, output, 1 / 1: pipeline stall for the IF stage and the MEM stage.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY_I and BUSY_D.
REQ-015 In IDLE with d_req=1 and starve_cnt<STARVE_MAX, the next state SHALL be BUSY_D.
REQ-016 In IDLE with if_req=1 and either d_req=0 or starve_cnt==STARVE_MAX, the next state SHALL be BUSY_I.
REQ-017 On the IDLE->BUSY_x edge, the granted requester's address, we, wdata and be SHALL be latched; later changes to requester inputs SHALL be ignored for that transaction.
REQ-018 In BUSY_x, m_req SHALL be 1 and m_addr/m_we/m_wdata/m_be SHALL be driven from the latches and held stable until m_ready.
REQ-019 For a fetch transaction, m_we SHALL be 0 and m_be SHALL be 4'b1111.
REQ-020 In IDLE, m_req SHALL be 0.
REQ-021 When m_ready=1 in BUSY_x:
  - m_rdata SHALL be registered into x_rdata;
  - x_valid SHALL pulse for exactly one cycle on the next cycle;
  - the state SHALL return to IDLE.
REQ-022 Minimum latency, request to x_valid, SHALL be 2 cycles (request seen at cycle 0, m_req at cycle 1, m_ready at cycle 1, valid at cycle 2).
REQ-023 One idle bubble SHALL separate consecutive transactions; arbitration occurs only in IDLE.
REQ-024 x_rdata SHALL hold its value until the next completion for that port.
REQ-025 Arbitration counter starve_cnt:
  - SHALL increment on each BUSY_D grant made while if_req=1;
  - SHALL clear to 0 on each BUSY_I grant;
  - SHALL saturate at STARVE_MAX.
REQ-026 The wait counter SHALL count cycles spent in BUSY_x.
REQ-027 If the wait counter reaches TIMEOUT without m_ready:
  - x_valid and x_err SHALL pulse together;
  - x_rdata SHALL be left unchanged;
  - the state SHALL return to IDLE.
REQ-028 If m_ready and timeout occur in the same cycle, m_ready SHALL win (normal completion, err=0).
REQ-029 m_ready asserted in IDLE SHALL be ignored.
REQ-030 If a requester deasserts its request mid-transaction, the transaction SHALL still complete and pulse valid.
REQ-031 stall_if SHALL equal if_req & ~if_valid, and stall_mem SHALL equal d_req & ~d_valid (combinational).

Reset
REQ-032 While reset=1 at a rising clk edge, the following SHALL be forced:
  - state = IDLE;
  - starve_cnt = 0;
  - wait counter = 0;
  - all latches, if_rdata and d_rdata = 0;
  - if_valid, d_valid, if_err, d_err and m_req = 0.
REQ-033 Reset asserted mid-transaction SHALL abandon it with no valid pulse; m_req SHALL be 0 from the cycle after reset is sampled.

Structure
REQ-034 A shared package arb_pkg SHALL hold the state enum (IDLE, BUSY_I, BUSY_D) and the default values of STARVE_MAX and TIMEOUT.
REQ-035 The wait/timeout counter SHALL be a sub-module mem_arb_timer with inputs clk, reset, clear and en, and output expired.

Verification
REQ-036 Lone fetch: if_req=1, if_addr=0x40, m_ready high on the first m_req cycle -> m_addr=0x40, m_we=0, if_valid at cycle 2 with if_rdata=m_rdata, stall_if=1 during cycles 0-1.
REQ-037 Simultaneous requests: if_req=1 and d_req=1 (d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF) -> data granted first with m_we=1 and m_wdata=0xDEADBEEF; fetch granted after the bubble.
REQ-038 Starvation: if_req held with d_req held for 5 transactions, STARVE_MAX=4 -> grant order D,D,D,D,I,D.
REQ-039 Timeout: m_ready held 0 -> after 16 BUSY cycles, d_valid=1 and d_err=1 for one cycle, d_rdata unchanged, FSM returns to IDLE.
REQ-040 Reset in BUSY_D -> m_req=0 the next cycle, no d_valid, starve_cnt=0, and a new fetch after reset completes normally.
REQ-041 Address change mid-wait: d_addr changes from 0x10 to 0x20 while in BUSY_D -> m_addr stays 0x10 until m_ready.
